fruit_launcher: RTL and testbench
=================================

Name: fruit_launcher

Overview:
- Upstream trajectory generator for the per-fruit axis stepper. It drives that stepper's step periods (Tx, Ty), initial position, direction bits and synchronous reset.
- On a launch request it picks a pseudo-random start column and horizontal drift, then shapes a parabolic arc. It lengthens the vertical step period while the fruit rises, flips direction at the apex, and shortens the period while it falls.
- It watches the stepper's posy to detect the top clamp and the exit off the bottom of the 640x480 screen.

Parameters:
- GRAV_TICKS, 2500000, clock cycles between vertical-period updates
- T_MIN, 50000, fastest vertical step period (cycles/pixel)
- T_MAX, 800000, slowest vertical step period; reaching it means apex
- T_STEP, 20000, vertical period increment/decrement per gravity tick
- TX_BASE, 200000, minimum horizontal step period
- TX_STEP, 25000, horizontal period per unit of random speed
- START_Y, 470, launch row
- TOP_Y, 8, forced-apex row
- EXIT_Y, 478, row at or below which a falling fruit has left the screen

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- launch  in  1  single-cycle launch request
- kill  in  1  single-cycle abort (fruit sliced); returns to IDLE silently
- posy_in  in  9  current Y from the downstream stepper
- Tx  out  32  horizontal step period
- Ty  out  32  vertical step period
- initPosX  out  10  launch column
- initPosY  out  9  launch row
- dx  out  1  1 = X increments
- dy  out  1  1 = Y increments (falling), 0 = rising
- obj_rst  out  1  synchronous reset to the stepper; high holds it at initPos
- busy  out  1  high in LOAD/RISE/FALL
- apex  out  1  one-cycle pulse at the RISE->FALL transition
- done  out  1  one-cycle pulse when the fruit exits the bottom

Behaviour:
- All outputs are registered. Async reset (rst_n=0) sets:
  - state=IDLE
  - Tx=TX_BASE, Ty=T_MAX, initPosX=320, initPosY=START_Y, dx=1, dy=1
  - obj_rst=1, busy=0, apex=0, done=0
  - gravity counter=0, LFSR=16'hACE1
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in every state, never all-zero.
- States: IDLE, LOAD, RISE, FALL.
- IDLE:
  - obj_rst=1, busy=0.
  - On the edge that samples launch=1, go to LOAD and register:
    - initPosX = 64 + lfsr[8:0] (range 64..575)
    - initPosY = START_Y
    - dx = (initPosX < 320)
    - dy = 0
    - Tx = TX_BASE + lfsr[15:12]*TX_STEP
    - Ty = T_MIN
- LOAD:
  - Lasts exactly 1 cycle with obj_rst=1, so the stepper loads the new initPos.
  - Next edge: state RISE, obj_rst=0, gravity counter=0.
- RISE: the gravity counter counts 0..GRAV_TICKS-1 and wraps. On the wrap cycle:
  - If Ty+T_STEP >= T_MAX: Ty=T_MAX, dy=1, apex=1 for one cycle, go to FALL.
  - Otherwise Ty = Ty+T_STEP.
- RISE forced apex: if posy_in <= TOP_Y, take the apex transition immediately, regardless of the counter.
- FALL:
  - On the wrap cycle: Ty = T_MIN if Ty <= T_MIN+T_STEP, else Ty-T_STEP. The comparison is done before subtracting, so there is no underflow.
  - If posy_in >= EXIT_Y: done=1 for one cycle, go to IDLE, obj_rst=1.
- Priority:
  - kill beats everything in LOAD/RISE/FALL: go to IDLE, obj_rst=1, no done, no apex.
  - In RISE, apex beats the kill-less gravity update.
  - launch while busy is ignored.
  - launch and kill in the same cycle in IDLE: launch wins.
- Gravity counter holds at 0 in IDLE/LOAD.
- Arithmetic: 32-bit unsigned for periods; 10-bit for initPosX.
- Mid-operation rst_n deassertion: all state is cleared asynchronously; exiting reset lands in IDLE.

Optional Feature:
- Macro FRUIT_LAUNCHER_DRAG_EN.
- When defined: on each gravity-tick wrap in RISE and FALL, Tx = min(Tx+TX_STEP, T_MAX), giving horizontal drag.
- When undefined: Tx stays constant from LOAD until the next launch.

Test Plan:
Parameters for all scenarios: GRAV_TICKS=4, T_MIN=2, T_MAX=10, T_STEP=4, TX_BASE=20, TX_STEP=1, START_Y=470, TOP_Y=8, EXIT_Y=478.
- Reset then idle:
  - Stimulus: rst_n low, then high for 10 cycles, launch=0.
  - Response: obj_rst=1, busy=0, Ty=10, Tx=20, dy=1, initPosX=320, no apex/done pulses.
- Launch sequence:
  - Stimulus: pulse launch.
  - Response: next cycle busy=1, dy=0, Ty=2, initPosY=470, 64<=initPosX<=575, dx==(initPosX<320). One cycle later obj_rst=0 (RISE). Ty=6 after 4 cycles. At the next wrap Ty=10, dy=1, apex pulses once.
- Fall and exit:
  - Stimulus: after apex, hold posy_in=300.
  - Response: Ty goes 10->6->2->2 on successive 4-cycle wraps. Then posy_in=478 gives a done pulse of exactly 1 cycle, obj_rst=1, busy=0.
- Forced apex:
  - Stimulus: in RISE with Ty=2, drive posy_in=8.
  - Response: next edge dy=1, Ty=10, apex=1, state FALL.
- Kill and ignored launch:
  - Stimulus: launch again during RISE.
  - Response: no reload; Ty and initPosX unchanged.
  - Stimulus: then kill.
  - Response: next edge obj_rst=1, busy=0, no done pulse.
  - Stimulus: rst_n low mid-FALL.
  - Response: outputs take reset values immediately, with no clock edge.
- Drag (FRUIT_LAUNCHER_DRAG_EN defined):
  - Stimulus: launch with lfsr[15:12]=0.
  - Response: Tx=20, saturating at 10 immediately → Tx=10 after the first wrap.
  - With the macro undefined, Tx stays 20 through RISE and FALL.

Source files
------------

// File: rtl/fruit_launcher.sv
// Trajectory generator for one fruit: on launch it picks a pseudo-random
// start column and horizontal speed, then shapes a parabolic arc by
// stretching the vertical step period while rising and shrinking it while
// falling. Optional horizontal drag is enabled by FRUIT_LAUNCHER_DRAG_EN.
module fruit_launcher #(
    parameter int unsigned GRAV_TICKS = 2500000,
    parameter int unsigned T_MIN      = 50000,
    parameter int unsigned T_MAX      = 800000,
    parameter int unsigned T_STEP     = 20000,
    parameter int unsigned TX_BASE    = 200000,
    parameter int unsigned TX_STEP    = 25000,
    parameter int unsigned START_Y    = 470,
    parameter int unsigned TOP_Y      = 8,
    parameter int unsigned EXIT_Y     = 478
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        launch,
    input  logic        kill,
    input  logic [8:0]  posy_in,
    output logic [31:0] Tx,
    output logic [31:0] Ty,
    output logic [9:0]  initPosX,
    output logic [8:0]  initPosY,
    output logic        dx,
    output logic        dy,
    output logic        obj_rst,
    output logic        busy,
    output logic        apex,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, LOAD, RISE, FALL} state_t;

    state_t      state_q, state_d;
    logic [31:0] grav_cnt_q, grav_cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] tx_q, tx_d, ty_q, ty_d;
    logic [9:0]  init_x_q, init_x_d;
    logic [8:0]  init_y_q, init_y_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic        obj_rst_q, obj_rst_d, busy_q, busy_d;
    logic        apex_q, apex_d, done_q, done_d;

    logic [9:0]  launch_x;
    logic [31:0] tx_drag;
    logic        wrap;
    logic        in_air;

    // Next-state, LFSR, gravity counter and registered-output computation
    always_comb begin
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        launch_x   = 10'd64 + {1'b0, lfsr_q[8:0]};
        wrap       = (grav_cnt_q == GRAV_TICKS - 32'd1);
`ifdef FRUIT_LAUNCHER_DRAG_EN
        tx_drag    = (tx_q + TX_STEP >= T_MAX) ? T_MAX : tx_q + TX_STEP;
`else
        tx_drag    = tx_q;
`endif
        state_d    = state_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        init_x_d   = init_x_q;
        init_y_d   = init_y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        apex_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d  = LOAD;
                    init_x_d = launch_x;
                    init_y_d = 9'(START_Y);
                    dx_d     = (launch_x < 10'd320);
                    dy_d     = 1'b0;
                    tx_d     = TX_BASE + 32'(lfsr_q[15:12]) * TX_STEP;
                    ty_d     = T_MIN;
                end
            end
            LOAD: begin
                state_d = kill ? IDLE : RISE;
            end
            RISE: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    if (wrap) tx_d = tx_drag;
                    if ((posy_in <= 9'(TOP_Y)) || (wrap && (ty_q + T_STEP >= T_MAX))) begin
                        state_d = FALL;
                        ty_d    = T_MAX;
                        dy_d    = 1'b1;
                        apex_d  = 1'b1;
                    end else if (wrap) begin
                        ty_d = ty_q + T_STEP;
                    end
                end
            end
            FALL: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (posy_in >= 9'(EXIT_Y)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (wrap) begin
                    tx_d = tx_drag;
                    // Compare before subtracting so the period never underflows
                    ty_d = (ty_q <= T_MIN + T_STEP) ? T_MIN : ty_q - T_STEP;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter only runs while staying airborne; any entry to RISE starts at 0
        in_air     = (state_q == RISE || state_q == FALL) &&
                     (state_d == RISE || state_d == FALL);
        grav_cnt_d = (in_air && !wrap) ? grav_cnt_q + 32'd1 : '0;
        busy_d     = (state_d != IDLE);
        obj_rst_d  = (state_d == IDLE) || (state_d == LOAD);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grav_cnt_q <= '0;
            lfsr_q     <= 16'hACE1;
            tx_q       <= TX_BASE;
            ty_q       <= T_MAX;
            init_x_q   <= 10'd320;
            init_y_q   <= 9'(START_Y);
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            obj_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            apex_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grav_cnt_q <= grav_cnt_d;
            lfsr_q     <= lfsr_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            init_x_q   <= init_x_d;
            init_y_q   <= init_y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            obj_rst_q  <= obj_rst_d;
            busy_q     <= busy_d;
            apex_q     <= apex_d;
            done_q     <= done_d;
        end
    end

    assign Tx       = tx_q;
    assign Ty       = ty_q;
    assign initPosX = init_x_q;
    assign initPosY = init_y_q;
    assign dx       = dx_q;
    assign dy       = dy_q;
    assign obj_rst  = obj_rst_q;
    assign busy     = busy_q;
    assign apex     = apex_q;
    assign done     = done_q;

endmodule

// File: tb/tb_fruit_launcher.sv
// Bench for fruit_launcher: fixed trajectory table, async-reset sequence and
// randomized launches/kills/positions against a behavioural flight model.
module tb_fruit_launcher;

    localparam int G       = 4;
    localparam int T_MIN   = 2;
    localparam int T_MAX   = 10;
    localparam int T_STEP  = 4;
    localparam int TX_BASE = 20;
    localparam int TX_STEP = 1;
    localparam int START_Y = 470;
    localparam int TOP_Y   = 8;
    localparam int EXIT_Y  = 478;

    localparam int P_IDLE = 0, P_LOAD = 1, P_RISE = 2, P_FALL = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        launch, kill;
    logic [8:0]  posy_in;
    logic [31:0] Tx, Ty;
    logic [9:0]  initPosX;
    logic [8:0]  initPosY;
    logic        dx, dy, obj_rst, busy, apex, done;

    int n_tests = 0;
    int n_fail  = 0;

    fruit_launcher #(
        .GRAV_TICKS(G), .T_MIN(T_MIN), .T_MAX(T_MAX), .T_STEP(T_STEP),
        .TX_BASE(TX_BASE), .TX_STEP(TX_STEP), .START_Y(START_Y),
        .TOP_Y(TOP_Y), .EXIT_Y(EXIT_Y)
    ) dut (
        .clk(clk), .rst_n(rst_n), .launch(launch), .kill(kill),
        .posy_in(posy_in), .Tx(Tx), .Ty(Ty), .initPosX(initPosX),
        .initPosY(initPosY), .dx(dx), .dy(dy), .obj_rst(obj_rst),
        .busy(busy), .apex(apex), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural flight model ----------------
    int          m_ph, m_air, m_tx, m_ty, m_x, m_y;
    bit          m_dx, m_dy, m_apex, m_done;
    int unsigned m_lfsr;

    function automatic int unsigned lfsr_next(input int unsigned x);
        return ((x << 1) & 32'hFFFF) | ($countones(x & 32'hB400) & 1);
    endfunction

    function automatic void m_reset();
        m_ph = P_IDLE; m_air = 0; m_tx = TX_BASE; m_ty = T_MAX;
        m_x = 320; m_y = START_Y; m_dx = 1; m_dy = 1;
        m_apex = 0; m_done = 0; m_lfsr = 32'hACE1;
    endfunction

    function automatic void m_drag();
`ifdef FRUIT_LAUNCHER_DRAG_EN
        m_tx = (m_tx + TX_STEP > T_MAX) ? T_MAX : m_tx + TX_STEP;
`endif
    endfunction

    function automatic void model_edge(input bit l, input bit k, input int py);
        bit tick;
        m_apex = 0; m_done = 0;
        tick = (m_air % G) == G - 1;
        case (m_ph)
            P_IDLE: if (l) begin
                m_x  = 64 + int'(m_lfsr % 512);
                m_y  = START_Y;
                m_dx = (m_x < 320);
                m_dy = 0;
                m_tx = TX_BASE + int'(m_lfsr / 4096) * TX_STEP;
                m_ty = T_MIN;
                m_ph = P_LOAD;
            end
            P_LOAD: begin
                m_ph  = k ? P_IDLE : P_RISE;
                m_air = 0;
            end
            P_RISE: if (k) m_ph = P_IDLE;
            else begin
                if (tick) m_drag();
                if (py <= TOP_Y || (tick && m_ty + T_STEP >= T_MAX)) begin
                    m_ty = T_MAX; m_dy = 1; m_apex = 1; m_ph = P_FALL;
                end else if (tick) m_ty = m_ty + T_STEP;
                m_air++;
            end
            P_FALL: if (k) m_ph = P_IDLE;
            else if (py >= EXIT_Y) begin
                m_done = 1; m_ph = P_IDLE;
            end else begin
                if (tick) begin
                    m_drag();
                    m_ty = (m_ty - T_STEP < T_MIN) ? T_MIN : m_ty - T_STEP;
                end
                m_air++;
            end
            default: m_ph = P_IDLE;
        endcase
        m_lfsr = lfsr_next(m_lfsr);
    endfunction

    // ---------------- checking ----------------
    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void cmp_model(input string tag);
        chk({tag, ".Tx"},       Tx,               32'(m_tx));
        chk({tag, ".Ty"},       Ty,               32'(m_ty));
        chk({tag, ".initPosX"}, 32'(initPosX),    32'(m_x));
        chk({tag, ".initPosY"}, 32'(initPosY),    32'(m_y));
        chk({tag, ".dx"},       32'(dx),          32'(m_dx));
        chk({tag, ".dy"},       32'(dy),          32'(m_dy));
        chk({tag, ".obj_rst"},  32'(obj_rst),     32'(m_ph == P_IDLE || m_ph == P_LOAD));
        chk({tag, ".busy"},     32'(busy),        32'(m_ph != P_IDLE));
        chk({tag, ".apex"},     32'(apex),        32'(m_apex));
        chk({tag, ".done"},     32'(done),        32'(m_done));
    endfunction

    function automatic void chk_reset_vals(input string tag);
        chk({tag, ".Tx"},       Tx,            32'(TX_BASE));
        chk({tag, ".Ty"},       Ty,            32'(T_MAX));
        chk({tag, ".initPosX"}, 32'(initPosX), 32'd320);
        chk({tag, ".dy"},       32'(dy),       32'd1);
        chk({tag, ".obj_rst"},  32'(obj_rst),  32'd1);
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".apex"},     32'(apex),     32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
    endfunction

    task automatic cycle(input bit l, input bit k, input int py, input string tag);
        launch = l; kill = k; posy_in = 9'(py);
        @(posedge clk);
        model_edge(l, k, py);
        #1;
        cmp_model(tag);
    endtask

    // ---------------- directed trajectory table ----------------
    typedef struct {
        bit l; bit k; int py;
        bit busy; bit orst; bit apx; bit dn; bit dyv; int ty;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit l, input bit k, input int py, input bit b,
                                input bit o, input bit a, input bit d, input bit y, input int ty);
        vec_t v;
        v.l = l; v.k = k; v.py = py; v.busy = b; v.orst = o;
        v.apx = a; v.dn = d; v.dyv = y; v.ty = ty;
        tbl.push_back(v);
    endfunction

    initial begin
        string tg;
        int    r;

        rst_n = 1'b0; launch = 1'b0; kill = 1'b0; posy_in = 9'd300;
        m_reset();
        #12;
        chk_reset_vals("reset");
        cmp_model("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle(0, 0, 300, "idle");
        chk_reset_vals("idle10");

        //   l k  py   busy orst apex done dy  Ty
        add(1, 0, 300, 1,   1,   0,   0,   0,  2);   // LOAD
        add(0, 0, 300, 1,   0,   0,   0,   0,  2);   // RISE cnt0
        add(0, 0, 300, 1,   0,   0,   0,   0,  2);
        add(0, 0, 300, 1,   0,   0,   0,   0,  2);
        add(1, 0, 300, 1,   0,   0,   0,   0,  2);   // launch while busy ignored
        add(0, 0, 300, 1,   0,   0,   0,   0,  6);   // first wrap
        for (int i = 0; i < 3; i++) add(0, 0, 300, 1, 0, 0, 0, 0, 6);
        add(0, 0, 300, 1,   0,   1,   0,   1, 10);   // apex
        for (int i = 0; i < 3; i++) add(0, 0, 300, 1, 0, 0, 0, 1, 10);
        add(0, 0, 300, 1,   0,   0,   0,   1,  6);
        for (int i = 0; i < 3; i++) add(0, 0, 300, 1, 0, 0, 0, 1, 6);
        add(0, 0, 300, 1,   0,   0,   0,   1,  2);
        for (int i = 0; i < 3; i++) add(0, 0, 300, 1, 0, 0, 0, 1, 2);
        add(0, 0, 300, 1,   0,   0,   0,   1,  2);   // period floors at T_MIN
        add(0, 0, 478, 0,   1,   0,   1,   1,  2);   // exit -> done
        add(0, 0, 300, 0,   1,   0,   0,   1,  2);   // done lasts one cycle
        add(1, 1, 300, 1,   1,   0,   0,   0,  2);   // launch beats kill in IDLE
        add(0, 0, 300, 1,   0,   0,   0,   0,  2);
        add(0, 1, 300, 0,   1,   0,   0,   0,  2);   // kill: no done
        add(0, 0, 300, 0,   1,   0,   0,   0,  2);
        add(1, 0, 300, 1,   1,   0,   0,   0,  2);
        add(0, 0, 300, 1,   0,   0,   0,   0,  2);
        add(0, 0,   8, 1,   0,   1,   0,   1, 10);   // forced apex at top row
        add(0, 0, 300, 1,   0,   0,   0,   1, 10);

        for (int i = 0; i < tbl.size(); i++) begin
            tg = $sformatf("vec%0d", i);
            cycle(tbl[i].l, tbl[i].k, tbl[i].py, tg);
            chk({tg, ".busy_c"},  32'(busy),    32'(tbl[i].busy));
            chk({tg, ".orst_c"},  32'(obj_rst), 32'(tbl[i].orst));
            chk({tg, ".apex_c"},  32'(apex),    32'(tbl[i].apx));
            chk({tg, ".done_c"},  32'(done),    32'(tbl[i].dn));
            chk({tg, ".dy_c"},    32'(dy),      32'(tbl[i].dyv));
            chk({tg, ".Ty_c"},    Ty,           32'(tbl[i].ty));
            if (tbl[i].l && !busy) chk({tg, ".x_range"}, 32'(initPosX >= 64 && initPosX <= 575), 32'd1);
        end

        // Asynchronous reset while falling: outputs clear with no clock edge
        cycle(0, 0, 300, "fall_pre");
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk_reset_vals("async_rst");
        cmp_model("async_rst");
        rst_n = 1'b1;

        // Randomized flights
        for (int i = 0; i < 3000; i++) begin
            bit l, k;
            int py;
            l = ($urandom_range(0, 7) == 0);
            k = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 99);
            if (r < 4)       py = $urandom_range(0, TOP_Y);
            else if (r < 12) py = $urandom_range(EXIT_Y, 511);
            else             py = $urandom_range(TOP_Y + 1, EXIT_Y - 1);
            cycle(l, k, py, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
